// File: rtl/digit_serial_adder_pkg.sv
// Shared definitions for the digit-serial adder: state encoding, default geometry
// and the digit-counter width helper.
package digit_serial_adder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_DIGIT = 4;

  // ceil(log2(n)) with a floor of one bit so N=1 still has a counter
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/digit_serial_adder_rca_digit.sv
// DIGIT-bit ripple-carry slice built from full adders; also exposes the carry into
// the top bit so the caller can form signed overflow.
module rca_digit #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] i_a,
  input  logic [DIGIT-1:0] i_b,
  input  logic             i_ci,
  output logic [DIGIT-1:0] o_s,
  output logic             o_co,
  output logic             o_c_msb
);

  always_comb begin
    logic w_c;
    o_s     = '0;
    o_c_msb = 1'b0;
    w_c     = i_ci;
    for (int i = 0; i < DIGIT; i++) begin
      if (i == DIGIT - 1) o_c_msb = w_c;
      o_s[i] = i_a[i] ^ i_b[i] ^ w_c;
      w_c    = (i_a[i] & i_b[i]) | (w_c & (i_a[i] ^ i_b[i]));
    end
    o_co = w_c;
  end

endmodule

// File: rtl/digit_serial_adder.sv
// Multi-cycle add/subtract unit: one DIGIT-bit slice per clock, carry held between
// digits, start/busy/done handshake and signed-overflow flag.
//   state   | meaning
//   ST_IDLE | waiting for start
//   ST_RUN  | one digit per clock, N clocks
//   ST_DONE | one-cycle result pulse; start here chains straight into ST_RUN
module digit_serial_adder
  import digit_serial_adder_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DIGIT = DEF_DIGIT
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_x,
  input  logic [WIDTH-1:0] i_y,
  input  logic             i_c_in,
  input  logic             i_sub,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_c_out,
  output logic             o_overflow
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = cnt_width(N);

  if ((DIGIT < 1) || ((WIDTH % DIGIT) != 0)) begin : g_bad_cfg
    $error("digit_serial_adder: WIDTH must be a non-zero multiple of DIGIT");
  end

  state_t           r_state, r_next;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_xa, r_yb, r_part, r_sum;
  logic             r_carry, r_c_out, r_ovf;

  logic [DIGIT-1:0] w_s;
  logic             w_co, w_c_msb, w_last, w_load;
  logic [WIDTH-1:0] w_full;

  rca_digit #(.DIGIT(DIGIT)) u_rca (
    .i_a     (r_xa[DIGIT-1:0]),
    .i_b     (r_yb[DIGIT-1:0]),
    .i_ci    (r_carry),
    .o_s     (w_s),
    .o_co    (w_co),
    .o_c_msb (w_c_msb)
  );

  assign w_last = (r_cnt == CW'(N - 1));
  assign w_load = i_start && (r_state != ST_RUN);
  // New digit enters at the top; after N shifts the word is fully assembled
  assign w_full = (r_part >> DIGIT) | (WIDTH'(w_s) << (WIDTH - DIGIT));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= ST_IDLE;
    else       r_state <= r_next;
  end

  always_comb begin
    r_next = r_state;
    case (r_state)
      ST_IDLE: if (i_start) r_next = ST_RUN;
      ST_RUN:  if (w_last)  r_next = ST_DONE;
      ST_DONE: r_next = i_start ? ST_RUN : ST_IDLE;
      default: r_next = ST_IDLE;
    endcase
  end

  always_comb begin
    o_busy = (r_state == ST_RUN);
    o_done = (r_state == ST_DONE);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt   <= '0;
      r_xa    <= '0;
      r_yb    <= '0;
      r_part  <= '0;
      r_carry <= 1'b0;
      r_sum   <= '0;
      r_c_out <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (w_load) begin
      r_xa    <= i_x;
      r_yb    <= i_sub ? ~i_y : i_y;
      r_carry <= i_sub | i_c_in;
      r_cnt   <= '0;
    end else if (r_state == ST_RUN) begin
      r_xa    <= r_xa >> DIGIT;
      r_yb    <= r_yb >> DIGIT;
      r_carry <= w_co;
      r_part  <= w_full;
      r_cnt   <= w_last ? '0 : r_cnt + CW'(1);
      if (w_last) begin
        r_sum   <= w_full;
        r_c_out <= w_co;
        r_ovf   <= w_c_msb ^ w_co;
      end
    end
  end

  assign o_sum      = r_sum;
  assign o_c_out    = r_c_out;
  assign o_overflow = r_ovf;

endmodule

// File: tb/tb_digit_serial_adder.sv
// Randomized and directed checks of digit_serial_adder against a plain-arithmetic
// reference; a second WIDTH=DIGIT instance covers the single-cycle case.
module tb_digit_serial_adder;

  localparam int W  = 16;
  localparam int D  = 4;
  localparam int N  = W / D;
  localparam int W1 = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          i_start = 1'b0, i_c_in = 1'b0, i_sub = 1'b0;
  logic [W-1:0]  i_x = '0, i_y = '0;
  logic          o_busy, o_done, o_c_out, o_overflow;
  logic [W-1:0]  o_sum;

  logic          i1_start = 1'b0, i1_c_in = 1'b0, i1_sub = 1'b0;
  logic [W1-1:0] i1_x = '0, i1_y = '0;
  logic          o1_busy, o1_done, o1_c_out, o1_overflow;
  logic [W1-1:0] o1_sum;

  int n_tests = 0;
  int n_fail  = 0;

  logic [W-1:0] exp_sum  = '0;
  logic         exp_cout = 1'b0;
  logic         exp_ovf  = 1'b0;

  always #5 clk = ~clk;

  digit_serial_adder #(.WIDTH(W), .DIGIT(D)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(i_start), .i_x(i_x), .i_y(i_y),
    .i_c_in(i_c_in), .i_sub(i_sub), .o_busy(o_busy), .o_done(o_done),
    .o_sum(o_sum), .o_c_out(o_c_out), .o_overflow(o_overflow)
  );

  digit_serial_adder #(.WIDTH(W1), .DIGIT(W1)) dut1 (
    .i_clk(clk), .i_rst(rst), .i_start(i1_start), .i_x(i1_x), .i_y(i1_y),
    .i_c_in(i1_c_in), .i_sub(i1_sub), .o_busy(o1_busy), .o_done(o1_done),
    .o_sum(o1_sum), .o_c_out(o1_c_out), .o_overflow(o1_overflow)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Returns sum in [w-1:0], carry-out at bit w, signed overflow at bit w+1
  function automatic logic [63:0] ref_op(input int w, input longint x, input longint y,
                                         input bit cin, input bit sub);
    longint m, s, sx, sy, sr;
    bit co, ov;
    m  = longint'(1) << w;
    if (sub) begin s = x - y;       co = (x >= y); end
    else     begin s = x + y + cin; co = (s >= m); end
    sx = (x >= m / 2) ? x - m : x;
    sy = (y >= m / 2) ? y - m : y;
    sr = sub ? sx - sy : sx + sy + longint'(cin);
    ov = (sr >= m / 2) || (sr < -(m / 2));
    return 64'(s & (m - 1)) | (64'(co) << w) | (64'(ov) << (w + 1));
  endfunction

  task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic cin, input logic sub, input bit poke);
    logic [63:0] r;
    r = ref_op(W, longint'(x), longint'(y), cin, sub);
    i_x = x; i_y = y; i_c_in = cin; i_sub = sub; i_start = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0;
    i_x = 16'($urandom); i_y = 16'($urandom);
    i_c_in = 1'($urandom); i_sub = 1'($urandom);
    chk("busy_e0", o_busy, 1'b1);
    chk("done_e0", o_done, 1'b0);
    for (int k = 1; k <= N; k++) begin
      if (poke && k == 1) begin i_start = 1'b1; i_x = 16'd100; i_y = 16'd100; end
      @(posedge clk); #1;
      i_start = 1'b0;
      if (k < N) begin
        chk("busy_run", o_busy, 1'b1);
        chk("done_run", o_done, 1'b0);
        chk("sum_held", o_sum, exp_sum);
        chk("cout_held", o_c_out, exp_cout);
        chk("ovf_held", o_overflow, exp_ovf);
      end else begin
        exp_sum = r[W-1:0]; exp_cout = r[W]; exp_ovf = r[W+1];
        chk("done_en", o_done, 1'b1);
        chk("busy_en", o_busy, 1'b0);
        chk("sum", o_sum, exp_sum);
        chk("c_out", o_c_out, exp_cout);
        chk("overflow", o_overflow, exp_ovf);
      end
    end
  endtask

  task automatic idle_cycle();
    @(posedge clk); #1;
    chk("done_idle", o_done, 1'b0);
    chk("busy_idle", o_busy, 1'b0);
    chk("sum_idle", o_sum, exp_sum);
  endtask

  task automatic run_op1(input logic [W1-1:0] x, input logic [W1-1:0] y,
                         input logic cin, input logic sub);
    logic [63:0] r;
    r = ref_op(W1, longint'(x), longint'(y), cin, sub);
    i1_x = x; i1_y = y; i1_c_in = cin; i1_sub = sub; i1_start = 1'b1;
    @(posedge clk); #1;
    i1_start = 1'b0;
    i1_x = 4'($urandom); i1_y = 4'($urandom);
    chk("n1_busy_e0", o1_busy, 1'b1);
    chk("n1_done_e0", o1_done, 1'b0);
    @(posedge clk); #1;
    chk("n1_done", o1_done, 1'b1);
    chk("n1_busy", o1_busy, 1'b0);
    chk("n1_sum", o1_sum, r[W1-1:0]);
    chk("n1_c_out", o1_c_out, r[W1]);
    chk("n1_overflow", o1_overflow, r[W1+1]);
    @(posedge clk); #1;
    chk("n1_done_pulse", o1_done, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #12;
    chk("rst_busy", o_busy, 1'b0);
    chk("rst_done", o_done, 1'b0);
    chk("rst_sum", o_sum, 16'h0000);
    chk("rst_cout", o_c_out, 1'b0);
    chk("rst_ovf", o_overflow, 1'b0);
    chk("rst_n1_sum", o1_sum, 4'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    idle_cycle();

    run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b0);
    chk("dir_ovf_sum", o_sum, 16'h8000);
    chk("dir_ovf_flag", o_overflow, 1'b1);
    idle_cycle();
    run_op(16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 1'b0);
    chk("dir_carry_sum", o_sum, 16'hFFFE);
    chk("dir_carry_cout", o_c_out, 1'b1);
    idle_cycle();
    run_op(16'h0005, 16'h0007, 1'b1, 1'b1, 1'b0);
    chk("dir_borrow_sum", o_sum, 16'hFFFE);
    chk("dir_borrow_cout", o_c_out, 1'b0);
    idle_cycle();
    run_op(16'h8000, 16'h0001, 1'b0, 1'b1, 1'b0);
    chk("dir_subovf_sum", o_sum, 16'h7FFF);
    chk("dir_subovf_flag", o_overflow, 1'b1);
    idle_cycle();

    // start during RUN ignored, then back-to-back start held in DONE
    run_op(16'd3, 16'd4, 1'b0, 1'b0, 1'b1);
    chk("hs_sum7", o_sum, 16'd7);
    idle_cycle();
    idle_cycle();
    run_op(16'd3, 16'd4, 1'b0, 1'b0, 1'b1);
    run_op(16'd1, 16'd1, 1'b0, 1'b0, 1'b0);
    chk("hs_sum2", o_sum, 16'd2);
    idle_cycle();

    // asynchronous reset in the middle of an operation
    i_x = 16'h1234; i_y = 16'h1111; i_c_in = 1'b0; i_sub = 1'b0; i_start = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0;
    @(posedge clk); @(posedge clk); #3;
    rst = 1'b1;
    #1;
    exp_sum = '0; exp_cout = 1'b0; exp_ovf = 1'b0;
    chk("arst_busy", o_busy, 1'b0);
    chk("arst_done", o_done, 1'b0);
    chk("arst_sum", o_sum, 16'h0000);
    chk("arst_cout", o_c_out, 1'b0);
    chk("arst_ovf", o_overflow, 1'b0);
    #2;
    rst = 1'b0;
    idle_cycle();
    run_op(16'd1, 16'd2, 1'b0, 1'b0, 1'b0);
    chk("post_rst_sum", o_sum, 16'd3);
    idle_cycle();

    for (int i = 0; i < 40; i++) begin
      run_op(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom),
             ($urandom_range(0, 3) == 0));
      if ($urandom_range(0, 1) == 1) idle_cycle();
    end

    run_op1(4'd15, 4'd15, 1'b0, 1'b0);
    chk("n1_dir_sum", o1_sum, 4'd14);
    for (int i = 0; i < 8; i++)
      run_op1(4'($urandom), 4'($urandom), 1'($urandom), 1'($urandom));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/digit_serial_adder.md
Name: digit_serial_adder

Overview:
- Parametrised multi-cycle adder/subtractor, successor to the team's fixed 4-bit ripple-carry adder.
- Processes a WIDTH-bit operand pair DIGIT bits per clock through one DIGIT-bit ripple-carry slice, carrying between digits in a register.
- Adds a start/busy/done handshake, a subtract mode and signed-overflow detection.
- Sits as a shared arithmetic unit behind simple controllers that launch one operation at a time.

Parameters:
- WIDTH, 16, operand/result width in bits; must be a multiple of DIGIT, otherwise elaboration error.
- DIGIT, 4, bits processed per cycle; N = WIDTH/DIGIT cycles per operation.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  launch request; sampled on rising clk.
- x  input  WIDTH  operand A; sampled with start.
- y  input  WIDTH  operand B; sampled with start.
- c_in  input  1  carry-in for add mode; ignored when sub=1.
- sub  input  1  0 = x+y+c_in, 1 = x-y (x + ~y + 1); sampled with start.
- busy  output  1  high while the operation is in progress (RUN state).
- done  output  1  one-cycle pulse when the result registers update.
- sum  output  WIDTH  registered result; held until the next completion.
- c_out  output  1  carry out of the MSB; in sub mode 1 = no borrow.
- overflow  output  1  signed overflow = carry into MSB XOR carry out of MSB.

Behaviour:
- States: IDLE, RUN, DONE. Digit counter cnt counts 0..N-1. Internal registers: xa, yb (effective y, already inverted in sub mode), carry, partial-sum shift register.
- Reset (async, any state, including mid-operation): state=IDLE; cnt=0; carry=0; busy=0; done=0; sum=0; c_out=0; overflow=0. The in-flight operation is discarded.
- IDLE or DONE with start=1 at edge E0:
  - latch x and y (y inverted if sub=1);
  - carry = sub ? 1 : c_in;
  - cnt=0; state=RUN; busy=1 from E0.
- RUN, edge Ek (k=1..N): digit cnt (bits [cnt*DIGIT +: DIGIT]) is added in the slice with the registered carry. Slice result goes into the partial register; carry is updated; cnt increments.
- At edge EN (last digit):
  - sum = full assembled result; c_out = slice carry-out;
  - overflow = slice MSB carry-in XOR carry-out;
  - state=DONE; busy=0; done=1.
  - Latency: done is high exactly N cycles after the start edge.
- DONE lasts one cycle; done=0 at the next edge.
  - Next state is RUN if start=1 at that edge (back-to-back, no idle gap).
  - Otherwise next state is IDLE.
- start while in RUN is ignored. Operands do not change and no extra done pulse is produced.
- x, y, c_in and sub may change freely after the start edge without affecting the operation.
- sum, c_out and overflow never change during RUN. They update only at EN.
- N=1 (WIDTH=DIGIT): single RUN cycle; done one cycle after start.
- All arithmetic is modulo 2^WIDTH. No saturation.

Decomposition:
- Shared package: state encoding constants (IDLE/RUN/DONE), default WIDTH/DIGIT, and a width helper for cnt (ceil log2 of N, minimum 1).
- One sub-module: rca_digit, a parametrised DIGIT-bit ripple-carry slice built from full adders.
  - Inputs: a, b, ci.
  - Outputs: s, co, and c_msb (carry into the top bit, used for overflow).
- The top level holds the FSM, counter and registers only.

Test Plan (WIDTH=16, DIGIT=4 unless noted):
- Add, signed overflow: x=16'h7FFF, y=16'h0001, c_in=0, sub=0, start pulse -> busy high 4 cycles, done pulse at cycle 4, sum=16'h8000, c_out=0, overflow=1.
- Add, carry out: x=16'hFFFF, y=16'hFFFF, c_in=0 -> sum=16'hFFFE, c_out=1, overflow=0.
  - Repeat with WIDTH=4, DIGIT=4, x=15, y=15 -> sum=14, c_out=1, done 1 cycle after start.
- Subtract with borrow: x=16'h0005, y=16'h0007, sub=1, c_in=1 (must be ignored) -> sum=16'hFFFE, c_out=0, overflow=0.
  - Then x=16'h8000, y=16'h0001, sub=1 -> sum=16'h7FFF, c_out=1, overflow=1.
- Handshake:
  - Start x=3, y=4; re-assert start with x=100, y=100 during RUN -> only one done, sum=7.
  - Hold start high in the DONE cycle with x=1, y=1 -> new RUN begins immediately; second done 4 cycles later with sum=2.
- Reset mid-operation: start x=16'h1234, y=16'h1111; assert rst after 2 cycles -> busy, done, sum, c_out and overflow go to 0 immediately (asynchronously).
  - Release rst, then start x=1, y=2 -> sum=3 after 4 cycles.
